fetch_sequencer: RTL

- Sequences instruction fetch for the single-issue RV32I core.
- Owns the architectural PC and issues one request at a time to instruction memory over a valid/ready request channel with an unbackpressurable response.
- Delivers {instr, pc, pc+4} to decode under a stall input.
- Handles branch/jump redirects from execute, including discard of in-flight stale responses.

---
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - RV32I instruction fetch sequencer; optional perf counters under FETCH_PERF_COUNTERS_EN
module fetch_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [WIDTH-1:0] instr_pc_plus4
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]      fetch_count,
  output logic [31:0]      discard_count
`endif
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             discard;
  logic [31:0]      buf_instr;
  logic [WIDTH-1:0] buf_pc;

  logic slot_free;
  logic req_fire;
  logic resp_drop;
  logic load_resp;
  logic store_resp;
  logic load_buf;

  // The decode slot can take a new word when empty or being consumed this cycle.
  assign slot_free  = !instr_valid || !stall;
  assign pc_plus4   = pc + PC_STEP;
  assign req_fire   = (state == REQ) && slot_free && imem_req_ready;
  // A response is thrown away if it was already stale or a redirect lands with it.
  assign resp_drop  = (state == WAIT) && imem_resp_valid && (discard || redirect);
  assign load_resp  = (state == WAIT) && imem_resp_valid && !discard && !redirect && slot_free;
  assign store_resp = (state == WAIT) && imem_resp_valid && !discard && !redirect && !slot_free;
  assign load_buf   = (state == HOLD) && !redirect && slot_free;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_next;
  end

  // Next-state: redirect only matters where it changes the normal path (HOLD exit).
  always_comb begin
    state_next = state;
    unique case (state)
      BOOT: state_next = REQ;
      REQ:  if (req_fire) state_next = WAIT;
      WAIT: if (imem_resp_valid) state_next = store_resp ? HOLD : REQ;
      HOLD: if (redirect || slot_free) state_next = REQ;
    endcase
  end

  // Request channel outputs; a request is only offered when its result has somewhere to go.
  always_comb begin
    imem_req_valid = (state == REQ) && slot_free;
    imem_addr      = pc;
  end

  // PC, stale-response flag, skid buffer and decode outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc             <= RESET_PC;
      discard        <= 1'b0;
      buf_instr      <= '0;
      buf_pc         <= '0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      instr_pc_plus4 <= '0;
    end else if (redirect) begin
      pc          <= redirect_target & ALIGN_MASK;
      instr_valid <= 1'b0;
      buf_instr   <= '0;
      buf_pc      <= '0;
      if (req_fire || ((state == WAIT) && !imem_resp_valid)) discard <= 1'b1;
      else if (resp_drop)                                    discard <= 1'b0;
    end else begin
      if (resp_drop) discard <= 1'b0;
      if (load_resp || store_resp) pc <= pc_plus4;
      if (store_resp) begin
        buf_instr <= imem_resp_data;
        buf_pc    <= pc;
      end
      if (load_resp) begin
        instr          <= imem_resp_data;
        instr_pc       <= pc;
        instr_pc_plus4 <= pc_plus4;
        instr_valid    <= 1'b1;
      end else if (load_buf) begin
        instr          <= buf_instr;
        instr_pc       <= buf_pc;
        instr_pc_plus4 <= buf_pc + PC_STEP;
        instr_valid    <= 1'b1;
      end else if (instr_valid && !stall) begin
        instr_valid    <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // Count words delivered to decode and responses thrown away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count   <= '0;
      discard_count <= '0;
    end else begin
      if (load_resp || load_buf) fetch_count   <= fetch_count + 32'd1;
      if (resp_drop)             discard_count <= discard_count + 32'd1;
    end
  end
`endif

endmodule
